// File: rtl/hilo_ctrl.sv
// HI/LO architectural register pair with a single-op interlock behind the dmu mult/div unit.
// Latency: HI/LO captured PIPE_DEPTH+1 non-stalled clocks after issue; MF read is combinational.
// Backpressure: stall_req holds the issuing stage while an op is pending; dmu_stall freezes the countdown.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   op_valid, op_type   mult/div issue (0101 mult, 0110 multu, 1011 div, 0111 divu)
//   dmu_hi, dmu_lo      dmu results, valid in the completion (WB) cycle
//   dmu_stall           dmu busy; freezes the pending countdown
//   flush               exception flush; cancels the pending op, HI/LO untouched
//   mt_hi, mt_lo,       MTHI/MTLO write requests and shared write data
//   mt_data
//   mf_req, mf_sel      MFHI/MFLO read request; mf_sel 1 = HI, 0 = LO
//   mf_data             read data, valid when mf_req=1 and stall_req=0
//   stall_req           hold the issuing stage
//   hi_q, lo_q          current HI/LO
//
// Build option: define HILO_FWD_EN to forward dmu hi/lo to MF reads in the
// completion cycle and to accept a new op in that same cycle.

module hilo_ctrl #(
   parameter int WIDTH      = 32,
   parameter int PIPE_DEPTH = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             op_valid,
   input  logic [3:0]       op_type,
   input  logic [WIDTH-1:0] dmu_hi,
   input  logic [WIDTH-1:0] dmu_lo,
   input  logic             dmu_stall,
   input  logic             flush,
   input  logic             mt_hi,
   input  logic             mt_lo,
   input  logic [WIDTH-1:0] mt_data,
   input  logic             mf_req,
   input  logic             mf_sel,
   output logic [WIDTH-1:0] mf_data,
   output logic             stall_req,
   output logic [WIDTH-1:0] hi_q,
   output logic [WIDTH-1:0] lo_q
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PEND = 2'd1,
      S_WB   = 2'd2
   } state_t;

   // Countdown starts at PIPE_DEPTH-1 so that WB is reached after exactly
   // PIPE_DEPTH non-stalled clocks following the issue edge.
   localparam logic [3:0] CNT_INIT = 4'(PIPE_DEPTH - 1);

   state_t     state_q;
   logic [3:0] cnt_q;
   logic       op_legal;
   logic       fwd_wb;

   assign op_legal = op_valid &&
                     ((op_type == 4'b0101) || (op_type == 4'b0110) ||
                      (op_type == 4'b1011) || (op_type == 4'b0111));

   // fwd_wb marks the completion cycle in which the bypass is active.
`ifdef HILO_FWD_EN
   assign fwd_wb = (state_q == S_WB);
`else
   assign fwd_wb = 1'b0;
`endif

   // Any request while an op is in flight waits; in the bypassed completion
   // cycle only MT writes still wait, since they must land after the capture.
   always_comb begin
      stall_req = 1'b0;
      if (state_q != S_IDLE) begin
         if (fwd_wb) begin
            stall_req = mt_hi | mt_lo;
         end else begin
            stall_req = op_valid | mt_hi | mt_lo | mf_req;
         end
      end
   end

   // Outside the bypass the architectural registers are read; the value is
   // only meaningful when stall_req is low, which restricts it to IDLE.
   always_comb begin
      mf_data = mf_sel ? hi_q : lo_q;
      if (fwd_wb) begin
         mf_data = mf_sel ? dmu_hi : dmu_lo;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else if (flush) begin
         // Cancel the pending op; HI/LO keep their last committed values.
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (mt_hi) hi_q <= mt_data;
               if (mt_lo) lo_q <= mt_data;
               if (op_legal) begin
                  state_q <= S_PEND;
                  cnt_q   <= CNT_INIT;
               end
            end
            S_PEND: begin
               if (!dmu_stall) begin
                  if (cnt_q == 4'd0) begin
                     state_q <= S_WB;
                  end else begin
                     cnt_q <= cnt_q - 4'd1;
                  end
               end
            end
            S_WB: begin
               hi_q <= dmu_hi;
               lo_q <= dmu_lo;
               if (fwd_wb && op_legal) begin
                  state_q <= S_PEND;
                  cnt_q   <= CNT_INIT;
               end else begin
                  state_q <= S_IDLE;
                  cnt_q   <= '0;
               end
            end
            default: begin
               state_q <= S_IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hilo_ctrl.sv
module tb_hilo_ctrl;
   localparam int W  = 32;
   localparam int PD = 5;
`ifdef HILO_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst, op_valid, dmu_stall, flush, mt_hi, mt_lo, mf_req, mf_sel;
   logic [3:0]    op_type;
   logic [W-1:0]  dmu_hi, dmu_lo, mt_data;
   logic [W-1:0]  mf_data, hi_q, lo_q;
   logic          stall_req;

   always #5 clk = ~clk;

   hilo_ctrl #(.WIDTH(W), .PIPE_DEPTH(PD)) dut (
      .clk(clk), .rst(rst), .op_valid(op_valid), .op_type(op_type),
      .dmu_hi(dmu_hi), .dmu_lo(dmu_lo), .dmu_stall(dmu_stall), .flush(flush),
      .mt_hi(mt_hi), .mt_lo(mt_lo), .mt_data(mt_data),
      .mf_req(mf_req), .mf_sel(mf_sel), .mf_data(mf_data),
      .stall_req(stall_req), .hi_q(hi_q), .lo_q(lo_q)
   );

   int n_checks = 0;
   int n_err    = 0;

   // Reference model: an op is either absent or has seen m_adv non-stalled
   // clocks since issue; it completes once m_adv reaches PD.
   bit           m_busy = 1'b0;
   int           m_adv  = 0;
   logic [W-1:0] m_hi   = '0;
   logic [W-1:0] m_lo   = '0;

   logic         last_stall;
   logic [W-1:0] last_mf;

   typedef struct {
      logic         rst, flush, op_valid;
      logic [3:0]   op_type;
      logic         mt_hi, mt_lo;
      logic [W-1:0] mt_data;
      logic         mf_req, mf_sel;
      logic         exp_stall;
      logic [W-1:0] exp_mf, exp_hi, exp_lo;
   } vec_t;

   vec_t tbl[11];

   function automatic void chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   task automatic idle_in();
      rst = 0; op_valid = 0; op_type = 4'b0000; dmu_stall = 0; flush = 0;
      mt_hi = 0; mt_lo = 0; mt_data = '0; mf_req = 0; mf_sel = 0;
   endtask

   // One clock: check combinational outputs against the model, advance the
   // model with this cycle's inputs, then check the registered state.
   task automatic cyc();
      bit           in_wb, legal, exp_stall;
      logic [W-1:0] exp_mf;
      #2;
      in_wb     = m_busy && (m_adv == PD);
      legal     = op_valid && (op_type inside {4'b0101, 4'b0110, 4'b1011, 4'b0111});
      exp_stall = m_busy && (op_valid || mt_hi || mt_lo || mf_req);
      if (FWD && in_wb) exp_stall = mt_hi || mt_lo;
      exp_mf = (FWD && in_wb) ? (mf_sel ? dmu_hi : dmu_lo) : (mf_sel ? m_hi : m_lo);
      last_stall = stall_req;
      last_mf    = mf_data;
      chk("model_stall", stall_req, exp_stall);
      if (mf_req && !exp_stall) chk("model_mf", mf_data, exp_mf);
      if (rst) begin
         m_busy = 0; m_adv = 0; m_hi = '0; m_lo = '0;
      end else if (flush) begin
         m_busy = 0;
      end else if (!m_busy) begin
         if (mt_hi) m_hi = mt_data;
         if (mt_lo) m_lo = mt_data;
         if (legal) begin m_busy = 1; m_adv = 0; end
      end else if (in_wb) begin
         m_hi = dmu_hi; m_lo = dmu_lo; m_busy = 0;
         if (FWD && legal) begin m_busy = 1; m_adv = 0; end
      end else if (!dmu_stall) begin
         m_adv++;
      end
      @(posedge clk);
      #1;
      chk("model_hi", hi_q, m_hi);
      chk("model_lo", lo_q, m_lo);
   endtask

   initial begin
      bit got;
      int n_st;
      logic [W-1:0] old_hi;

      // Reset held for two clocks
      idle_in();
      dmu_hi = '0; dmu_lo = '0;
      rst = 1;
      @(posedge clk); @(posedge clk); #1;
      chk("rst_hi", hi_q, 0);
      chk("rst_lo", lo_q, 0);
      chk("rst_stall", stall_req, 0);
      chk("rst_mf_lo", mf_data, 0);
      mf_sel = 1; #1;
      chk("rst_mf_hi", mf_data, 0);
      idle_in();
      @(posedge clk); #1;

      // IDLE-only vectors: MT/MF ordering, flush, illegal op, mid-run reset
      tbl[0]  = '{0,0,0,4'h0, 1,0,32'hDEADBEEF, 0,0, 0,32'h0,        32'hDEADBEEF,32'h0};
      tbl[1]  = '{0,0,0,4'h0, 0,0,32'h0,        1,1, 0,32'hDEADBEEF, 32'hDEADBEEF,32'h0};
      tbl[2]  = '{0,0,0,4'h0, 0,1,32'h12345678, 1,0, 0,32'h0,        32'hDEADBEEF,32'h12345678};
      tbl[3]  = '{0,0,0,4'h0, 1,1,32'hA5A5A5A5, 1,1, 0,32'hDEADBEEF, 32'hA5A5A5A5,32'hA5A5A5A5};
      tbl[4]  = '{0,1,0,4'h0, 1,0,32'h00000001, 0,0, 0,32'h0,        32'hA5A5A5A5,32'hA5A5A5A5};
      tbl[5]  = '{0,0,1,4'h0, 0,0,32'h0,        1,0, 0,32'hA5A5A5A5, 32'hA5A5A5A5,32'hA5A5A5A5};
      tbl[6]  = '{0,0,0,4'h0, 0,0,32'h0,        1,1, 0,32'hA5A5A5A5, 32'hA5A5A5A5,32'hA5A5A5A5};
      tbl[7]  = '{1,0,0,4'h0, 1,0,32'hFFFFFFFF, 0,0, 0,32'h0,        32'h0,       32'h0};
      tbl[8]  = '{0,0,0,4'h0, 0,0,32'h0,        1,1, 0,32'h0,        32'h0,       32'h0};
      tbl[9]  = '{0,1,1,4'h5, 0,0,32'h0,        0,0, 0,32'h0,        32'h0,       32'h0};
      tbl[10] = '{0,0,0,4'h0, 0,0,32'h0,        1,0, 0,32'h0,        32'h0,       32'h0};
      for (int i = 0; i < 11; i++) begin
         idle_in();
         rst = tbl[i].rst; flush = tbl[i].flush; op_valid = tbl[i].op_valid;
         op_type = tbl[i].op_type; mt_hi = tbl[i].mt_hi; mt_lo = tbl[i].mt_lo;
         mt_data = tbl[i].mt_data; mf_req = tbl[i].mf_req; mf_sel = tbl[i].mf_sel;
         cyc();
         chk($sformatf("tbl%0d_stall", i), last_stall, tbl[i].exp_stall);
         if (tbl[i].mf_req) chk($sformatf("tbl%0d_mf", i), last_mf, tbl[i].exp_mf);
         chk($sformatf("tbl%0d_hi", i), hi_q, tbl[i].exp_hi);
         chk($sformatf("tbl%0d_lo", i), lo_q, tbl[i].exp_lo);
      end

      // mult: capture exactly PD+1 clocks after issue
      idle_in(); mt_lo = 1; mt_data = 32'h22; cyc();
      idle_in(); dmu_hi = 32'h0; dmu_lo = 32'h15; op_valid = 1; op_type = 4'b0101; cyc();
      idle_in();
      for (int k = 1; k <= PD + 1; k++) begin
         cyc();
         chk($sformatf("mult_lo_edge%0d", k), lo_q, (k == PD + 1) ? 32'h15 : 32'h22);
      end
      chk("mult_hi", hi_q, 32'h0);

      // div with 30 stalled clocks; MFLO waits for the result
      idle_in(); dmu_hi = 32'h1; dmu_lo = 32'h2; op_valid = 1; op_type = 4'b1011; cyc();
      idle_in(); dmu_stall = 1; mf_req = 1; mf_sel = 0;
      for (int k = 0; k < 30; k++) cyc();
      chk("div_stall_held", last_stall, 1);
      chk("div_frozen_lo", lo_q, 32'h15);
      dmu_stall = 0; got = 0;
      for (int k = 1; k <= PD + 1; k++) begin
         cyc();
         if (!got && !last_stall) begin got = 1; chk("div_mflo_data", last_mf, 32'h2); end
         chk($sformatf("div_lo_edge%0d", k), lo_q, (k == PD + 1) ? 32'h2 : 32'h15);
      end
      for (int k = 0; k < 3 && !got; k++) begin
         cyc();
         if (!last_stall) begin got = 1; chk("div_mflo_data", last_mf, 32'h2); end
      end
      chk("div_mflo_returned", got, 1);
      chk("div_hi", hi_q, 32'h1);

      // MTHI in IDLE then MFHI; MTHI during PEND overrides the op's HI
      idle_in(); mt_hi = 1; mt_data = 32'hDEADBEEF; cyc();
      idle_in(); mf_req = 1; mf_sel = 1; cyc();
      chk("mfhi_after_mthi_stall", last_stall, 0);
      chk("mfhi_after_mthi_data", last_mf, 32'hDEADBEEF);
      idle_in(); dmu_hi = 32'h99; dmu_lo = 32'h77; op_valid = 1; op_type = 4'b0101; cyc();
      idle_in(); mt_hi = 1; mt_data = 32'hDEADBEEF; got = 0; n_st = 0;
      for (int k = 0; k < 20 && !got; k++) begin
         cyc();
         if (last_stall) n_st++; else got = 1;
      end
      idle_in();
      chk("mthi_pend_done", got, 1);
      chk("mthi_pend_stalls", n_st, PD + 1);
      chk("mthi_pend_hi", hi_q, 32'hDEADBEEF);
      chk("mthi_pend_lo", lo_q, 32'h77);

      // multu flushed on its second clock: nothing captured
      idle_in(); mt_hi = 1; mt_data = 32'h11; cyc();
      idle_in(); mt_lo = 1; mt_data = 32'h22; cyc();
      idle_in(); dmu_hi = 32'hBAD0; dmu_lo = 32'hBAD1; op_valid = 1; op_type = 4'b0110; cyc();
      idle_in(); cyc();
      flush = 1; mf_req = 1; cyc();
      chk("flush_cycle_stall", last_stall, 1);
      flush = 0; cyc();
      chk("flush_next_stall", last_stall, 0);
      chk("flush_next_mf", last_mf, 32'h22);
      idle_in();
      for (int k = 0; k < PD + 4; k++) cyc();
      chk("flush_hi_kept", hi_q, 32'h11);
      chk("flush_lo_kept", lo_q, 32'h22);

      // MFHI in the completion cycle
      old_hi = hi_q;
      idle_in(); dmu_hi = 32'hCAFE0001; dmu_lo = 32'hCAFE0002; op_valid = 1; op_type = 4'b0111; cyc();
      idle_in();
      for (int k = 0; k < PD; k++) cyc();
      mf_req = 1; mf_sel = 1; cyc();
      chk("mfhi_wb_stall", last_stall, !FWD);
      chk("mfhi_wb_data", last_mf, FWD ? 32'hCAFE0001 : old_hi);
      cyc();
      chk("mfhi_after_wb_stall", last_stall, 0);
      chk("mfhi_after_wb_data", last_mf, 32'hCAFE0001);
      chk("mfhi_after_wb_hi", hi_q, 32'hCAFE0001);

      // Randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         idle_in();
         rst       = ($urandom_range(0, 99) == 0);
         flush     = ($urandom_range(0, 29) == 0);
         op_valid  = ($urandom_range(0, 3) == 0);
         case ($urandom_range(0, 4))
            0: op_type = 4'b0101;
            1: op_type = 4'b0110;
            2: op_type = 4'b1011;
            3: op_type = 4'b0111;
            default: op_type = 4'($urandom);
         endcase
         dmu_stall = ($urandom_range(0, 2) == 0);
         mt_hi     = ($urandom_range(0, 7) == 0);
         mt_lo     = ($urandom_range(0, 7) == 0);
         mt_data   = $urandom;
         mf_req    = ($urandom_range(0, 2) == 0);
         mf_sel    = 1'($urandom);
         dmu_hi    = $urandom;
         dmu_lo    = $urandom;
         cyc();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
